// File: rtl/ram_burst_ctrl.sv
// Burst initiator for a single-port synchronous-write / async-read RAM.
// Host issues (addr, len, dir) commands; beats stream in/out with valid/ready.
module ram_burst_ctrl #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  cur_addr;
    logic [LEN_W-1:0]   remaining;
    logic [LEN_W-1:0]   issue_left;
    logic [LEN_W-1:0]   len_eff;
    logic               load;

    // Oversized lengths are clamped to one full pass over the RAM.
    assign len_eff = ({1'b0, cmd_len} > (LEN_W+1)'(DEPTH)) ? LEN_W'(DEPTH) : cmd_len;

    // Read output register refills whenever it is empty or being drained.
    assign load = (state == READ) && (!rd_valid || rd_ready) && (issue_left != '0);

    assign ram_we    = wr_ready && wr_valid && !rst;
    assign ram_addr  = cur_addr;
    assign ram_wdata = wr_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            wr_ready   <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            cur_addr   <= '0;
            remaining  <= '0;
            issue_left <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cur_addr   <= cmd_addr;
                        remaining  <= len_eff;
                        issue_left <= len_eff;
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        if (len_eff == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (cmd_write) begin
                            state    <= WRITE;
                            wr_ready <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                WRITE: begin
                    if (wr_valid) begin
                        cur_addr  <= cur_addr + ADDR_W'(1);
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state    <= DONE;
                            wr_ready <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (load) begin
                        rd_data    <= ram_rdata;
                        rd_valid   <= 1'b1;
                        cur_addr   <= cur_addr + ADDR_W'(1);
                        issue_left <= issue_left - LEN_W'(1);
                    end else if (rd_ready) begin
                        rd_valid <= 1'b0;
                    end
                    // Burst ends on the consumer handshake of the last beat.
                    if (rd_valid && rd_ready) begin
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl with a behavioural 1024x32 RAM attached.
// Inputs are driven and outputs sampled 1ns after the rising edge.
module tb_ram_burst_ctrl;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 11;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic [DATA_W-1:0] mem [0:1023];

    int errors = 0;
    int checks = 0;

    ram_burst_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
    assign ram_rdata = mem[ram_addr];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic w, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        tick();
        cmd_valid = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] word(input logic [7:0] tag, input int i);
        return {tag, tag, 16'h0000} | DATA_W'(i);
    endfunction

    task automatic test_reset;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        tick(); tick();
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        checks++;
        if ({busy, done, wr_ready, rd_valid, ram_we} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 00000", {busy, done, wr_ready, rd_valid, ram_we});
        end
        checks++;
        if (ram_addr !== '0 || rd_data !== '0) begin
            errors++; $display("FAIL reset_regs: got addr=%h data=%h want 0/0", ram_addr, rd_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_burst;
        send_cmd(1'b1, 10'h010, 11'd4);
        checks++;
        if ({busy, cmd_ready, wr_ready} !== 3'b101) begin
            errors++; $display("FAIL wr_accept: got busy/cmd_ready/wr_ready=%b want 101", {busy, cmd_ready, wr_ready});
        end
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = word(8'hA0, i);
            #1;
            checks++;
            if (ram_we !== 1'b1 || ram_addr !== ADDR_W'(10'h010 + i) || ram_wdata !== word(8'hA0, i)) begin
                errors++; $display("FAIL wr_beat%0d: got we=%b addr=%h data=%h want 1/%h/%h",
                                   i, ram_we, ram_addr, ram_wdata, ADDR_W'(10'h010 + i), word(8'hA0, i));
            end
            tick();
        end
        wr_valid = 1'b0;
        #1;
        checks++;
        if ({done, busy, ram_we} !== 3'b110) begin
            errors++; $display("FAIL wr_done: got done/busy/we=%b want 110", {done, busy, ram_we});
        end
        tick();
        checks++;
        if ({done, busy, cmd_ready} !== 3'b001) begin
            errors++; $display("FAIL wr_idle: got done/busy/cmd_ready=%b want 001", {done, busy, cmd_ready});
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[10'h010 + i] !== word(8'hA0, i)) begin
                errors++; $display("FAIL wr_mem%0d: got %h want %h", i, mem[10'h010 + i], word(8'hA0, i));
            end
        end
    endtask

    task automatic test_read_burst;
        rd_ready = 1'b1;
        send_cmd(1'b0, 10'h010, 11'd4);
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_first_latency: got rd_valid=%b want 0", rd_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== word(8'hA0, i)) begin
                errors++; $display("FAIL rd_beat%0d: got v=%b data=%h want 1/%h", i, rd_valid, rd_data, word(8'hA0, i));
            end
        end
        tick();
        checks++;
        if ({done, rd_valid} !== 2'b10) begin
            errors++; $display("FAIL rd_done: got done/rd_valid=%b want 10", {done, rd_valid});
        end
        rd_ready = 1'b0;
        tick();
    endtask

    task automatic test_wrap;
        logic [ADDR_W-1:0] a;
        send_cmd(1'b1, 10'h3FE, 11'd4);
        for (int i = 0; i < 4; i++) begin
            a = ADDR_W'(10'h3FE + i);
            wr_valid = 1'b1;
            wr_data  = word(8'hB0, i);
            #1;
            checks++;
            if (ram_we !== 1'b1 || ram_addr !== a) begin
                errors++; $display("FAIL wrap_wr%0d: got we=%b addr=%h want 1/%h", i, ram_we, ram_addr, a);
            end
            tick();
        end
        wr_valid = 1'b0;
        tick();
        rd_ready = 1'b1;
        send_cmd(1'b0, 10'h3FE, 11'd4);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== word(8'hB0, i)) begin
                errors++; $display("FAIL wrap_rd%0d: got v=%b data=%h want 1/%h", i, rd_valid, rd_data, word(8'hB0, i));
            end
        end
        tick();
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b want 1", done); end
        rd_ready = 1'b0;
        tick();
    endtask

    task automatic test_backpressure;
        bit [0:4] pat = 5'b10011;
        bit [0:5] wp  = 6'b101001;
        int got = 0;
        int beats = 0;
        bit stall = 1'b0;
        bit seen = 1'b0;
        logic [DATA_W-1:0] held = '0;
        send_cmd(1'b0, 10'h010, 11'd3);
        for (int k = 0; k < 20 && !seen; k++) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                rd_ready = (k < 5) ? pat[k] : 1'b1;
                #1;
                if (stall) begin
                    checks++;
                    if (rd_valid !== 1'b1 || rd_data !== held) begin
                        errors++; $display("FAIL bp_hold: got v=%b data=%h want 1/%h", rd_valid, rd_data, held);
                    end
                end
                if (rd_valid && rd_ready) begin
                    checks++;
                    if (got >= 3 || rd_data !== word(8'hA0, got)) begin
                        errors++; $display("FAIL bp_beat%0d: got %h want %h", got, rd_data, word(8'hA0, got));
                    end
                    got++;
                end
                stall = rd_valid && !rd_ready;
                held  = rd_data;
                tick();
            end
        end
        checks++;
        if (!seen || got != 3) begin errors++; $display("FAIL bp_count: got beats=%0d done=%b want 3/1", got, seen); end
        rd_ready = 1'b0;
        tick();

        seen = 1'b0;
        send_cmd(1'b1, 10'h020, 11'd3);
        for (int k = 0; k < 20 && !seen; k++) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                wr_valid = (k < 6) ? wp[k] : 1'b1;
                wr_data  = word(8'hC0, beats);
                #1;
                checks++;
                if (ram_we !== wr_valid) begin
                    errors++; $display("FAIL gap_we%0d: got %b want %b", k, ram_we, wr_valid);
                end
                if (wr_valid) begin
                    if (ram_addr !== ADDR_W'(10'h020 + beats)) begin
                        checks++; errors++;
                        $display("FAIL gap_addr%0d: got %h want %h", beats, ram_addr, ADDR_W'(10'h020 + beats));
                    end
                    beats++;
                end
                tick();
            end
        end
        wr_valid = 1'b0;
        checks++;
        if (!seen || beats != 3) begin errors++; $display("FAIL gap_count: got beats=%0d done=%b want 3/1", beats, seen); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem[10'h020 + i] !== word(8'hC0, i)) begin
                errors++; $display("FAIL gap_mem%0d: got %h want %h", i, mem[10'h020 + i], word(8'hC0, i));
            end
        end
        tick();
    endtask

    task automatic test_null;
        wr_valid = 1'b1;
        #1;
        checks++;
        if (ram_we !== 1'b0) begin errors++; $display("FAIL idle_we: got %b want 0", ram_we); end
        send_cmd(1'b1, 10'h050, 11'd0);
        checks++;
        if ({done, busy, ram_we, rd_valid, wr_ready} !== 5'b11000) begin
            errors++; $display("FAIL null_wr: got done/busy/we/rv/wrdy=%b want 11000", {done, busy, ram_we, rd_valid, wr_ready});
        end
        wr_valid = 1'b0;
        tick();
        checks++;
        if ({done, busy} !== 2'b00) begin errors++; $display("FAIL null_wr_end: got done/busy=%b want 00", {done, busy}); end
        rd_ready = 1'b1;
        send_cmd(1'b0, 10'h050, 11'd0);
        checks++;
        if ({done, rd_valid} !== 2'b10) begin errors++; $display("FAIL null_rd: got done/rv=%b want 10", {done, rd_valid}); end
        rd_ready = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        send_cmd(1'b1, 10'h050, 11'd0);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h010; cmd_len = 11'd1;
        rd_ready = 1'b1;
        tick();
        checks++;
        if ({busy, cmd_ready, done} !== 3'b010) begin
            errors++; $display("FAIL b2b_ignored: got busy/cmd_ready/done=%b want 010", {busy, cmd_ready, done});
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({busy, rd_valid} !== 2'b10) begin errors++; $display("FAIL b2b_accept: got busy/rv=%b want 10", {busy, rd_valid}); end
        tick();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== word(8'hA0, 0)) begin
            errors++; $display("FAIL b2b_data: got v=%b data=%h want 1/%h", rd_valid, rd_data, word(8'hA0, 0));
        end
        tick();
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", done); end
        rd_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        send_cmd(1'b1, 10'h040, 11'd5);
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1;
            wr_data  = word(8'hD0, i);
            tick();
        end
        wr_valid = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if ({cmd_ready, busy, done, wr_ready, rd_valid, ram_we} !== 6'b100000 || ram_addr !== '0 || rd_data !== '0) begin
            errors++; $display("FAIL mid_reset: got flags=%b addr=%h data=%h want 100000/0/0",
                               {cmd_ready, busy, done, wr_ready, rd_valid, ram_we}, ram_addr, rd_data);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({done, busy} !== 2'b00) begin errors++; $display("FAIL mid_no_done: got done/busy=%b want 00", {done, busy}); end
        rd_ready = 1'b1;
        send_cmd(1'b0, 10'h040, 11'd2);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== word(8'hD0, i)) begin
                errors++; $display("FAIL mid_rd%0d: got v=%b data=%h want 1/%h", i, rd_valid, rd_data, word(8'hD0, i));
            end
        end
        tick();
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL mid_rd_done: got %b want 1", done); end
        rd_ready = 1'b0;
        tick();
    endtask

    task automatic test_oversize;
        int cnt = 0;
        bit seen = 1'b0;
        rd_ready = 1'b1;
        $display("note: issuing illegal cmd_len=2047, controller should clamp to 1024 beats");
        send_cmd(1'b0, 10'h000, 11'd2047);
        for (int k = 0; k < 1200 && !seen; k++) begin
            if (done) seen = 1'b1;
            else begin
                if (rd_valid) cnt++;
                tick();
            end
        end
        checks++;
        if (!seen || cnt != 1024) begin errors++; $display("FAIL oversize: got beats=%0d done=%b want 1024/1", cnt, seen); end
        rd_ready = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_wrap();
        test_backpressure();
        test_null();
        test_back_to_back();
        test_reset_mid();
        test_oversize();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
